// File: rtl/param_cache.sv
// param_cache: direct-mapped parameter cache with a request/ack handshake.
//
// Each line holds a tag, a valid bit, a dirty bit and WORDS data words.
// A request is captured in IDLE when enable is high. Ordinary requests take
// one ACCESS cycle; invalidate-all requests sweep one line per cycle. Both
// finish in DONE, where ack and the outputs hold until enable is released.
//
// Optional feature: define PARAM_CACHE_STATS_EN to add the saturating
// hit_cnt / miss_cnt outputs that count compare operations.
//
// Ports:
//   clk       clock, rising edge active
//   rst       asynchronous active-high reset
//   enable    request strobe, held until ack
//   inv_all   request is invalidate-all
//   index     line select
//   word      word select within the line
//   comp      compare mode
//   write     write mode
//   tag_in    tag for compare or write
//   data_in   write data
//   valid_in  valid bit for access-write
//   hit       tag match on a valid line (compare ops only)
//   dirty     line dirty bit before the op
//   tag_out   stored tag
//   data_out  selected word (pre-write)
//   valid     line valid bit before the op
//   ack       request complete, outputs stable
//   hit_cnt   (stats build) compare hits, saturating
//   miss_cnt  (stats build) compare misses, saturating
module param_cache #(
    parameter int SETS   = 16,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16,
    localparam int IW    = $clog2(SETS),
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              inv_all,
    input  logic [IW-1:0]     index,
    input  logic [WW-1:0]     word,
    input  logic              comp,
    input  logic              write,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              hit,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              ack
`ifdef PARAM_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, SWEEP, DONE} state_e;

    state_e              state_q;
    logic [IW-1:0]       swp_q;
    logic [SETS-1:0]     vld_q;
    logic [SETS-1:0]     dty_q;

    // Captured request (data path, no reset needed)
    logic [IW-1:0]       idx_q;
    logic [WW-1:0]       word_q;
    logic                comp_q;
    logic                write_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_in_q;

    // Registered outputs
    logic                hit_q;
    logic                dirty_q;
    logic                valid_q;
    logic [TAG_W-1:0]    tag_out_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                ack_q;

    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [DATA_W-1:0]   data_mem [SETS][WORDS];

    logic                hit_d;
    logic                wr_en;

`ifdef PARAM_CACHE_STATS_EN
    logic [15:0]         hit_cnt_q;
    logic [15:0]         miss_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign hit_d = comp_q && vld_q[idx_q] && (tag_mem[idx_q] == tag_q);

    // Compare-write only touches the array on a hit; access-write always does.
    assign wr_en = (state_q == ACCESS) && write_q && (!comp_q || hit_d);

    assign hit      = hit_q;
    assign dirty    = dirty_q;
    assign valid    = valid_q;
    assign tag_out  = tag_out_q;
    assign data_out = data_out_q;
    assign ack      = ack_q;

    // Request capture: later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && enable) begin
            idx_q      <= index;
            word_q     <= word;
            comp_q     <= comp;
            write_q    <= write;
            tag_q      <= tag_in;
            data_q     <= data_in;
            valid_in_q <= valid_in;
        end
    end

    // Tag and data arrays. A reset while in ACCESS drops the state to IDLE
    // before the next edge, so an aborted request never writes here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[idx_q][word_q] <= data_q;
            if (!comp_q) begin
                tag_mem[idx_q] <= tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            swp_q      <= '0;
            vld_q      <= '0;
            dty_q      <= '0;
            hit_q      <= 1'b0;
            dirty_q    <= 1'b0;
            valid_q    <= 1'b0;
            tag_out_q  <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
`ifdef PARAM_CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (inv_all) begin
                            state_q    <= SWEEP;
                            swp_q      <= '0;
                            hit_q      <= 1'b0;
                            dirty_q    <= 1'b0;
                            valid_q    <= 1'b0;
                            tag_out_q  <= '0;
                            data_out_q <= '0;
`ifdef PARAM_CACHE_STATS_EN
                            hit_cnt_q  <= '0;
                            miss_cnt_q <= '0;
`endif
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Outputs report the line as it was before this op.
                    hit_q      <= hit_d;
                    dirty_q    <= dty_q[idx_q];
                    valid_q    <= vld_q[idx_q];
                    tag_out_q  <= tag_mem[idx_q];
                    data_out_q <= data_mem[idx_q][word_q];
                    if (write_q) begin
                        if (!comp_q) begin
                            vld_q[idx_q] <= valid_in_q;
                            dty_q[idx_q] <= 1'b0;
                        end else if (hit_d) begin
                            dty_q[idx_q] <= 1'b1;
                        end
                    end
`ifdef PARAM_CACHE_STATS_EN
                    if (comp_q) begin
                        if (hit_d) begin
                            hit_cnt_q <= sat_inc(hit_cnt_q);
                        end else begin
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                        end
                    end
`endif
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                SWEEP: begin
                    vld_q[swp_q] <= 1'b0;
                    dty_q[swp_q] <= 1'b0;
                    if (swp_q == IW'(SETS - 1)) begin
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        swp_q <= swp_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_cache.sv
// Randomized bench for param_cache with a behavioural line/word model.
module tb_param_cache;

    localparam int SETS   = 16;
    localparam int WORDS  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        inv_all = 1'b0;
    logic [3:0]  index = '0;
    logic [1:0]  word = '0;
    logic        comp = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  tag_in = '0;
    logic [15:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        hit, dirty, valid, ack;
    logic [4:0]  tag_out;
    logic [15:0] data_out;
`ifdef PARAM_CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    param_cache #(.SETS(SETS), .WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .inv_all(inv_all),
        .index(index), .word(word), .comp(comp), .write(write),
        .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in),
        .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
        .valid(valid), .ack(ack)
`ifdef PARAM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents of the cache as the rules describe them.
    bit m_valid [SETS];
    bit m_dirty [SETS];
    int m_tag   [SETS];
    int m_data  [SETS][WORDS];
    int m_hc = 0;
    int m_mc = 0;
    bit chk_td = 1'b0;   // tag/data contents known to the model

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hc = 0;
        m_mc = 0;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_dirty"}, int'(dirty), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_tag"}, int'(tag_out), 0);
        chk({tag, "_data"}, int'(data_out), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero_outs("rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_req(input bit inv, input int idx, input int wd, input bit cmp,
                          input bit wr, input int tg, input int dat, input bit vin,
                          input int hold, input bit drop_early);
        int cyc;
        int e_hit, e_dirty, e_valid, e_tag, e_data;
        if (inv) begin
            e_hit = 0; e_dirty = 0; e_valid = 0; e_tag = 0; e_data = 0;
        end else begin
            e_valid = int'(m_valid[idx]);
            e_dirty = int'(m_dirty[idx]);
            e_tag   = m_tag[idx];
            e_data  = m_data[idx][wd];
            e_hit   = (cmp && m_valid[idx] && m_tag[idx] == tg) ? 1 : 0;
        end
        @(negedge clk);
        inv_all  = inv;
        index    = 4'(idx);
        word     = 2'(wd);
        comp     = cmp;
        write    = wr;
        tag_in   = 5'(tg);
        data_in  = 16'(dat);
        valid_in = vin;
        enable   = 1'b1;
        @(posedge clk);
        #1;
        // Captured request must ignore anything that happens on the inputs now.
        inv_all  = 1'($urandom);
        index    = 4'($urandom);
        word     = 2'($urandom);
        comp     = 1'($urandom);
        write    = 1'($urandom);
        tag_in   = 5'($urandom);
        data_in  = 16'($urandom);
        valid_in = 1'($urandom);
        if (drop_early) enable = 1'b0;
        cyc = 1;
        while (!ack && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ack_latency", cyc, inv ? SETS + 1 : 2);
        chk("hit", int'(hit), e_hit);
        chk("dirty", int'(dirty), e_dirty);
        chk("valid", int'(valid), e_valid);
        if (chk_td || inv) begin
            chk("tag_out", int'(tag_out), e_tag);
            chk("data_out", int'(data_out), e_data);
        end
        // Commit the operation into the model.
        if (inv) begin
            for (int i = 0; i < SETS; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            m_hc = 0;
            m_mc = 0;
        end else if (cmp) begin
            if (e_hit != 0) m_hc = (m_hc < 65535) ? m_hc + 1 : m_hc;
            else            m_mc = (m_mc < 65535) ? m_mc + 1 : m_mc;
            if (wr && e_hit != 0) begin
                m_data[idx][wd] = dat;
                m_dirty[idx] = 1'b1;
            end
        end else if (wr) begin
            m_tag[idx] = tg;
            m_data[idx][wd] = dat;
            m_valid[idx] = vin;
            m_dirty[idx] = 1'b0;
        end
`ifdef PARAM_CACHE_STATS_EN
        chk("hit_cnt", int'(hit_cnt), m_hc);
        chk("miss_cnt", int'(miss_cnt), m_mc);
`endif
        if (drop_early) begin
            @(posedge clk);
            #1 chk("ack_after_early_drop", int'(ack), 0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("hold_ack", int'(ack), 1);
                chk("hold_hit", int'(hit), e_hit);
                chk("hold_valid", int'(valid), e_valid);
                if (chk_td || inv) chk("hold_data", int'(data_out), e_data);
            end
            @(negedge clk);
            enable = 1'b0;
            @(posedge clk);
            #1 chk("ack_release", int'(ack), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Every line reads back invalid and clean after reset.
        for (int i = 0; i < SETS; i++) do_req(0, i, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill tags and data so the model knows every word; lines stay invalid.
        for (int i = 0; i < SETS; i++)
            for (int w = 0; w < WORDS; w++)
                do_req(0, i, w, 0, 1, int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 65535)), 0, 0, 0);
        chk_td = 1'b1;

        // Access-write then compare-read.
        do_req(0, 3, 2, 0, 1, 'h0A, 'hBEEF, 1, 0, 0);
        do_req(0, 3, 2, 1, 0, 'h0A, 0, 0, 0, 0);
        // Compare-write hit, readback with dirty, compare-write miss.
        do_req(0, 3, 2, 1, 1, 'h0A, 'h1234, 0, 0, 0);
        do_req(0, 3, 2, 1, 0, 'h0A, 0, 0, 0, 0);
        do_req(0, 3, 2, 1, 1, 'h0B, 'h5555, 0, 0, 0);
        do_req(0, 3, 2, 1, 0, 'h0A, 0, 0, 5, 0);

        // Invalidate-all, then the line no longer hits.
        do_req(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        do_req(0, 3, 2, 1, 0, 'h0A, 0, 0, 0, 0);

        // Statistics: three hits, two misses, access ops don't count.
        do_req(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_req(0, 5, 1, 0, 1, 3, 'h00AA, 1, 0, 0);
        for (int i = 0; i < 3; i++) do_req(0, 5, 1, 1, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) do_req(0, 5, 1, 1, 0, 4, 0, 0, 0, 0);
        do_req(0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PARAM_CACHE_STATS_EN
        chk("stats_hits3", int'(hit_cnt), 3);
        chk("stats_miss2", int'(miss_cnt), 2);
`endif

        // Enable dropped during ACCESS and during SWEEP.
        do_req(0, 5, 1, 1, 0, 3, 0, 0, 0, 1);
        do_req(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of a sweep.
        do_req(0, 7, 0, 0, 1, 9, 'h7777, 1, 0, 0);
        @(negedge clk);
        inv_all = 1'b1;
        enable  = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero_outs("rst_sweep");
        model_reset();
        enable  = 1'b0;
        inv_all = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 7, 0, 1, 0, 9, 0, 0, 0, 0);

        // Reset in the middle of an access-write: nothing gets written.
        do_req(0, 3, 2, 0, 1, 'h0A, 'h4321, 1, 0, 0);
        @(negedge clk);
        index = 4'd3; word = 2'd2; comp = 1'b0; write = 1'b1;
        tag_in = 5'h1F; data_in = 16'hDEAD; valid_in = 1'b1; enable = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero_outs("rst_access");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        do_req(0, 3, 2, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            do_req($urandom_range(0, 19) == 0, int'($urandom_range(0, SETS - 1)),
                   int'($urandom_range(0, WORDS - 1)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(8, 11)), int'($urandom_range(0, 65535)),
                   $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
